// File: rtl/parity_check_rx.sv
// Receive-side parity checker: recomputes parity on each accepted word and forwards
// data plus a per-word error flag through a 2-entry FIFO, with sticky/counting status.
module parity_check_rx #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    input  logic              clr_err,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    function automatic logic parity_err(input logic [DATA_W-1:0] d, input logic p);
        return ((^d) ^ p) != ODD;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [DATA_W-1:0]   head_data_q, head_data_d;
    logic                head_err_q, head_err_d;
    logic [DATA_W-1:0]   tail_data_q, tail_data_d;
    logic                tail_err_q, tail_err_d;
    logic                sticky_q, sticky_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                acc, emit, new_err;

    assign acc     = in_valid && in_ready_q;
    assign emit    = (state_q != EMPTY) && out_ready;
    assign new_err = parity_err(in_data, in_parity);

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_err_d  = head_err_q;
        tail_data_d = tail_data_q;
        tail_err_d  = tail_err_q;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    head_data_d = in_data;
                    head_err_d  = new_err;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (acc && emit) begin
                    head_data_d = in_data;
                    head_err_d  = new_err;
                end else if (acc) begin
                    tail_data_d = in_data;
                    tail_err_d  = new_err;
                    state_d     = TWO;
                end else if (emit) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (emit) begin
                    head_data_d = tail_data_q;
                    head_err_d  = tail_err_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        in_ready_d = (state_d != TWO);
    end

    // Clear takes effect first so a same-cycle erroneous accept still counts once.
    always_comb begin
        sticky_d = clr_err ? 1'b0 : sticky_q;
        cnt_d    = clr_err ? '0 : cnt_q;
        if (acc && new_err) begin
            sticky_d = 1'b1;
            cnt_d    = sat_inc(cnt_d);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            head_data_q <= '0;
            head_err_q  <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            head_data_q <= head_data_d;
            head_err_q  <= head_err_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        tail_data_q <= tail_data_d;
        tail_err_q  <= tail_err_d;
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != EMPTY);
    assign out_data   = head_data_q;
    assign out_err    = head_err_q;
    assign err_sticky = sticky_q;
    assign err_count  = cnt_q;

endmodule

// File: tb/tb_parity_check_rx.sv
// Directed bench for parity_check_rx: even-parity instance with a 2-bit counter
// and an odd-parity instance with the default counter width.
module tb_parity_check_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance A: even parity, CNT_W = 2
    logic       a_reset, a_in_valid, a_in_ready, a_in_parity, a_out_valid, a_out_ready;
    logic       a_out_err, a_clr_err, a_err_sticky;
    logic [7:0] a_in_data, a_out_data;
    logic [1:0] a_err_count;

    parity_check_rx #(.DATA_W(8), .ODD(1'b0), .CNT_W(2)) u_a (
        .clk(clk), .reset(a_reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_parity(a_in_parity),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_err(a_out_err),
        .clr_err(a_clr_err), .err_sticky(a_err_sticky), .err_count(a_err_count)
    );

    // Instance B: odd parity, CNT_W = 16
    logic        b_reset, b_in_valid, b_in_ready, b_in_parity, b_out_valid, b_out_ready;
    logic        b_out_err, b_clr_err, b_err_sticky;
    logic [7:0]  b_in_data, b_out_data;
    logic [15:0] b_err_count;

    parity_check_rx #(.DATA_W(8), .ODD(1'b1), .CNT_W(16)) u_b (
        .clk(clk), .reset(b_reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_parity(b_in_parity),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_err(b_out_err),
        .clr_err(b_clr_err), .err_sticky(b_err_sticky), .err_count(b_err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic [7:0] d, input logic p);
        a_in_valid  = v;
        a_in_data   = d;
        a_in_parity = p;
    endtask

    initial begin
        a_reset = 1'b1; a_out_ready = 1'b0; a_clr_err = 1'b0; a_drive(1'b0, 8'h00, 1'b0);
        b_reset = 1'b1; b_out_ready = 1'b0; b_clr_err = 1'b0;
        b_in_valid = 1'b0; b_in_data = 8'h00; b_in_parity = 1'b0;
        step();
        a_reset = 1'b0; b_reset = 1'b0;

        // Reset state
        chk("rst_in_ready",  a_in_ready, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data",  a_out_data, 0);
        chk("rst_out_err",   a_out_err, 0);
        chk("rst_sticky",    a_err_sticky, 0);
        chk("rst_count",     a_err_count, 0);

        // Even parity: 0xA5/0 is good, 0x01/0 is bad
        a_out_ready = 1'b1;
        a_drive(1'b1, 8'hA5, 1'b0);
        step();
        chk("ev1_valid", a_out_valid, 1);
        chk("ev1_data",  a_out_data, 8'hA5);
        chk("ev1_err",   a_out_err, 0);
        chk("ev1_count", a_err_count, 0);
        a_drive(1'b1, 8'h01, 1'b0);
        step();
        chk("ev2_data",   a_out_data, 8'h01);
        chk("ev2_err",    a_out_err, 1);
        chk("ev2_count",  a_err_count, 1);
        chk("ev2_sticky", a_err_sticky, 1);
        a_drive(1'b0, 8'h00, 1'b0);
        step();
        chk("ev_drain", a_out_valid, 0);

        // Backpressure: 0x11, 0x22, 0x33 with out_ready low
        a_out_ready = 1'b0;
        a_drive(1'b1, 8'h11, 1'b0);
        step();
        chk("bp1_ready", a_in_ready, 1);
        chk("bp1_data",  a_out_data, 8'h11);
        a_drive(1'b1, 8'h22, 1'b0);
        step();
        chk("bp2_ready", a_in_ready, 0);
        chk("bp2_data",  a_out_data, 8'h11);
        a_drive(1'b1, 8'h33, 1'b0);
        step();
        chk("bp3_ready", a_in_ready, 0);
        chk("bp3_data",  a_out_data, 8'h11);
        step();
        chk("bp4_ready", a_in_ready, 0);
        chk("bp4_data",  a_out_data, 8'h11);
        a_out_ready = 1'b1;
        step();
        chk("bp5_data",  a_out_data, 8'h22);
        chk("bp5_ready", a_in_ready, 1);
        step();
        chk("bp6_data",  a_out_data, 8'h33);
        chk("bp6_valid", a_out_valid, 1);
        a_drive(1'b0, 8'h00, 1'b0);
        step();
        chk("bp7_valid", a_out_valid, 0);
        chk("bp_count",  a_err_count, 1);

        // Clear, then five mismatching words saturate the 2-bit counter
        a_clr_err = 1'b1;
        step();
        a_clr_err = 1'b0;
        chk("clr0_count",  a_err_count, 0);
        chk("clr0_sticky", a_err_sticky, 0);
        a_drive(1'b1, 8'h01, 1'b0);
        step(); chk("sat1", a_err_count, 1); chk("sat1_sticky", a_err_sticky, 1);
        step(); chk("sat2", a_err_count, 2);
        step(); chk("sat3", a_err_count, 3);
        step(); chk("sat4", a_err_count, 3);
        step(); chk("sat5", a_err_count, 3); chk("sat5_sticky", a_err_sticky, 1);

        // clr_err coincident with a mismatching accept
        a_clr_err = 1'b1;
        step();
        chk("clrerr_count",  a_err_count, 1);
        chk("clrerr_sticky", a_err_sticky, 1);
        a_drive(1'b0, 8'h00, 1'b0);
        step();
        a_clr_err = 1'b0;
        chk("clronly_count",  a_err_count, 0);
        chk("clronly_sticky", a_err_sticky, 0);
        step();
        chk("clr_drained", a_out_valid, 0);

        // Reset with two buffered error words and err_count = 2
        a_out_ready = 1'b0;
        a_drive(1'b1, 8'h01, 1'b0);
        step();
        a_drive(1'b1, 8'h03, 1'b1);
        step();
        chk("pre_rst_count", a_err_count, 2);
        chk("pre_rst_ready", a_in_ready, 0);
        a_reset = 1'b1;
        a_drive(1'b1, 8'h77, 1'b1);
        step();
        a_reset = 1'b0;
        a_drive(1'b0, 8'h00, 1'b0);
        chk("mid_rst_valid",  a_out_valid, 0);
        chk("mid_rst_ready",  a_in_ready, 1);
        chk("mid_rst_count",  a_err_count, 0);
        chk("mid_rst_sticky", a_err_sticky, 0);
        chk("mid_rst_data",   a_out_data, 0);
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_valid", a_out_valid, 0);
        end

        // Odd parity instance
        b_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_data = 8'h00; b_in_parity = 1'b1;
        step();
        chk("odd1_data", b_out_data, 8'h00);
        chk("odd1_err",  b_out_err, 0);
        b_in_data = 8'hFF; b_in_parity = 1'b1;
        step();
        chk("odd2_data",  b_out_data, 8'hFF);
        chk("odd2_err",   b_out_err, 0);
        chk("odd2_count", b_err_count, 0);
        b_in_data = 8'h00; b_in_parity = 1'b0;
        step();
        chk("odd3_err",    b_out_err, 1);
        chk("odd3_count",  b_err_count, 1);
        chk("odd3_sticky", b_err_sticky, 1);
        b_in_valid = 1'b0;
        step();
        chk("odd_drain", b_out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
